// File: rtl/regchk_pkg.sv
// Shared definitions for the register-file self-check engine: FSM encoding
// and the elaboration-time check that the table index can hold NUM_CHECKS.
package regchk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } regchk_state_e;

    // True when an idx_w-bit index can represent the value num_checks.
    function automatic bit idx_w_fits(input int unsigned idx_w, input int unsigned num_checks);
        if (idx_w >= 32'd32) begin
            return 1'b1;
        end else begin
            return (num_checks < (32'd1 << idx_w));
        end
    endfunction

endpackage

// File: rtl/regchk_sat_counter.sv
// Saturating error counter: clear has priority, increment stops at all-ones
// so a non-zero count never wraps back to zero.
module regchk_sat_counter
    import regchk_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next-count selection
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/regfile_check_engine.sv
// On-chip regfile self-check: wait CYCLE_LIMIT cycles after start, then compare
// one table entry per cycle against the regfile. Optional macro: REGCHK_MASK_EN.
module regfile_check_engine
    import regchk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned REG_ADDR_W  = 5,
    parameter int unsigned NUM_CHECKS  = 8,
    parameter int unsigned CYCLE_LIMIT = 11,
    parameter int unsigned IDX_W       = 8,
    parameter int unsigned ERR_W       = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic [IDX_W-1:0]      tbl_idx,
    input  logic [REG_ADDR_W-1:0] tbl_reg,
    input  logic [DATA_WIDTH-1:0] tbl_expected,
`ifdef REGCHK_MASK_EN
    input  logic [DATA_WIDTH-1:0] tbl_mask,
`endif
    output logic [REG_ADDR_W-1:0] rf_addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      error_count,
    output logic [IDX_W-1:0]      first_fail_idx,
    output logic [DATA_WIDTH-1:0] first_fail_read
);

    localparam int unsigned WAIT_W = (CYCLE_LIMIT > 32'd1) ? $clog2(CYCLE_LIMIT) : 32'd1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((CYCLE_LIMIT == 32'd0) ? 32'd0 : CYCLE_LIMIT - 32'd1);
    localparam logic [IDX_W-1:0] LAST_IDX =
        IDX_W'((NUM_CHECKS == 32'd0) ? 32'd0 : NUM_CHECKS - 32'd1);

    if (!idx_w_fits(IDX_W, NUM_CHECKS)) begin : g_idx_w_too_small
        $error("regfile_check_engine: IDX_W too narrow for NUM_CHECKS");
    end

    regchk_state_e          state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [IDX_W-1:0]       ffi_q, ffi_d;
    logic [DATA_WIDTH-1:0]  ffr_q, ffr_d;
    logic [DATA_WIDTH-1:0]  diff_s;
    logic                   mismatch_s;
    logic                   in_check_s;
    logic                   run_start_s;
    logic                   err_inc_s;
    logic [ERR_W-1:0]       err_cnt_s;

`ifdef REGCHK_MASK_EN
    assign diff_s = (rf_data ^ tbl_expected) & tbl_mask;
`else
    assign diff_s = rf_data ^ tbl_expected;
`endif

    assign mismatch_s  = |diff_s;
    assign in_check_s  = (state_q == ST_CHECK);
    assign run_start_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign err_inc_s   = in_check_s && mismatch_s;

    regchk_sat_counter #(
        .W(ERR_W)
    ) u_err_cnt (
        .clk_i   (clock),
        .rst_i   (reset),
        .clr_i   (run_start_s),
        .inc_i   (err_inc_s),
        .count_o (err_cnt_s)
    );

    // Next-state, wait/index counters and first-failure capture
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        idx_d   = '0;
        ffi_d   = ffi_q;
        ffr_d   = ffr_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    wait_d = '0;
                    ffi_d  = '0;
                    ffr_d  = '0;
                    if (CYCLE_LIMIT != 32'd0) begin
                        state_d = ST_WAIT;
                    end else if (NUM_CHECKS == 32'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d = '0;
                    if (NUM_CHECKS == 32'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_CHECK;
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_CHECK: begin
                // A zero count means no earlier mismatch: the counter never wraps
                if (mismatch_s && (err_cnt_s == '0)) begin
                    ffi_d = idx_q;
                    ffr_d = rf_data;
                end else begin
                    ffi_d = ffi_q;
                    ffr_d = ffr_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered status decode from the next state
    always_comb begin
        busy_d = (state_d == ST_WAIT) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
        if (state_d != ST_DONE) begin
            pass_d = 1'b0;
        end else if (run_start_s) begin
            pass_d = 1'b1;
        end else begin
            pass_d = (err_cnt_s == '0) && !err_inc_s;
        end
    end

    // State and status registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            ffi_q   <= '0;
            ffr_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            ffi_q   <= ffi_d;
            ffr_q   <= ffr_d;
        end
    end

    assign tbl_idx         = idx_q;
    assign rf_addr         = in_check_s ? tbl_reg : '0;
    assign busy            = busy_q;
    assign done            = done_q;
    assign pass            = pass_q;
    assign error_count     = err_cnt_s;
    assign first_fail_idx  = ffi_q;
    assign first_fail_read = ffr_q;

endmodule
